// File: rtl/divider_cmd_assembler_if.sv
// Byte-stream command port and assembled-command outputs of the divider command assembler.
interface divider_cmd_assembler_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         write;
  logic [143:0] out_data;
  logic         busy;
  logic         frame_err;
  logic [7:0]   err_count;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, write, out_data, busy, frame_err, err_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, write, out_data, busy, frame_err, err_count
  );
endinterface

// File: rtl/divider_cmd_assembler.sv
// Assembles 18-byte command frames (header, mode, 64-bit numerator, 64-bit denominator),
// issues a one-cycle write, then locks out the byte stream while the divider runs.
module divider_cmd_assembler #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1024,
  parameter int         LOCKOUT = 72
) (
  input  logic                  divider_clk,
  input  logic                  divider_rst,
  divider_cmd_assembler_if.slave bus
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  // Expiry is flagged in the idle cycle that would carry the counter to TIMEOUT-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [LK_W-1:0] lk_q, lk_d;
  logic [143:0]    asm_q, asm_d;
  logic [143:0]    out_q, out_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      errc_q, errc_d;
  logic            live_q;

  logic            rdy;
  logic            accept;
  logic            mode_ok;
  logic [143:0]    shifted;

  assign rdy     = live_q && ((state_q == IDLE) || (state_q == COLLECT));
  assign accept  = bus.rx_valid && rdy;
  assign mode_ok = (bus.rx_data >= 8'h01) && (bus.rx_data <= 8'h05);
  assign shifted = {asm_q[135:0], bus.rx_data};

  assign bus.rx_ready  = rdy;
  assign bus.write     = (state_q == ISSUE);
  assign bus.busy      = (state_q == ISSUE) || (state_q == HOLD);
  assign bus.out_data  = out_q;
  assign bus.frame_err = ferr_q;
  assign bus.err_count = errc_q;

  always_ff @(posedge divider_clk or posedge divider_rst) begin
    if (divider_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      lk_q    <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      ferr_q  <= 1'b0;
      errc_q  <= 8'h00;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      lk_q    <= lk_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      ferr_q  <= ferr_d;
      errc_q  <= errc_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    lk_d    = lk_q;
    asm_d   = asm_q;
    out_d   = out_q;
    ferr_d  = 1'b0;
    errc_d  = errc_q;

    unique case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == HEADER)) begin
          asm_d   = {136'h0, bus.rx_data};
          cnt_d   = 5'd1;
          to_d    = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          to_d = '0;
          if (cnt_q == 5'd1) begin
            if (mode_ok) begin
              asm_d = shifted;
              cnt_d = 5'd2;
            end else begin
              ferr_d  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (cnt_q == 5'd17) begin
            asm_d   = shifted;
            out_d   = shifted;
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            asm_d = shifted;
            cnt_d = cnt_q + 5'd1;
          end
        end else if (to_q == TO_LAST) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ISSUE: begin
        lk_d    = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (lk_q == LK_LAST) begin
          lk_d    = '0;
          state_d = IDLE;
        end else begin
          lk_d = lk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ferr_d && (errc_q != 8'hFF)) begin
      errc_d = errc_q + 8'h01;
    end
  end

endmodule
